// File: rtl/mp3_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mp3_ctrl_pkg
// Description : Shared definitions for the MP3 player control path:
//               command codes, arbiter FSM state encoding, default
//               volume step/limit and per-channel saturating helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mp3_ctrl_pkg;

    // Command codes carried on i_bt_cmd / i_key_cmd
    localparam logic [2:0] C_CMD_NOP    = 3'd0;
    localparam logic [2:0] C_CMD_PAUSE  = 3'd1;
    localparam logic [2:0] C_CMD_NEXT   = 3'd2;
    localparam logic [2:0] C_CMD_PRE    = 3'd3;
    localparam logic [2:0] C_CMD_VOL_UP = 3'd4;
    localparam logic [2:0] C_CMD_VOL_DN = 3'd5;
    localparam logic [2:0] C_CMD_SEL    = 3'd6;
    localparam logic [2:0] C_CMD_RSVD   = 3'd7;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_LOAD = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Default volume arithmetic constants
    localparam int unsigned C_VOL_STEP = 14;
    localparam logic [7:0]  C_VOL_MAX  = 8'hFC;

    // Louder: reduce attenuation, floor at 0
    function automatic logic [7:0] vol_att_dec(input logic [7:0] ch,
                                               input logic [7:0] step);
        return (ch < step) ? 8'd0 : (ch - step);
    endfunction

    // Quieter: raise attenuation, ceiling at max. The compare against
    // (max - step) keeps the sum from ever wrapping the byte.
    function automatic logic [7:0] vol_att_inc(input logic [7:0] ch,
                                               input logic [7:0] step,
                                               input logic [7:0] max);
        return (ch > (max - step)) ? max : (ch + step);
    endfunction

endpackage
`default_nettype wire

// File: rtl/player_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : player_cmd_arbiter_if
// Description : Bundles both command requester handshakes, the decoder
//               load handshake and the player control state outputs.
//   slave  modport : the arbiter (consumes commands, drives state)
//   master modport : the front-ends / decoder side
//   i_bt_*  / o_bt_ready  : requester 0 (Bluetooth UART decoder)
//   i_key_* / o_key_ready : requester 1 (on-board keys)
//   o_vol, o_song_select, o_pause, o_next/o_pre/o_vol_plus/o_vol_dec
//   o_load_req / i_load_ack : decoder reload handshake (levels)
// Revision    : 1.0 - initial release
// ============================================================================
interface player_cmd_arbiter_if;
    logic        i_bt_valid;
    logic [2:0]  i_bt_cmd;
    logic [2:0]  i_bt_arg;
    logic        o_bt_ready;
    logic        i_key_valid;
    logic [2:0]  i_key_cmd;
    logic [2:0]  i_key_arg;
    logic        o_key_ready;
    logic [15:0] o_vol;
    logic [2:0]  o_song_select;
    logic        o_pause;
    logic        o_next;
    logic        o_pre;
    logic        o_vol_plus;
    logic        o_vol_dec;
    logic        o_load_req;
    logic        i_load_ack;

    modport slave (
        input  i_bt_valid, i_bt_cmd, i_bt_arg,
        input  i_key_valid, i_key_cmd, i_key_arg,
        input  i_load_ack,
        output o_bt_ready, o_key_ready,
        output o_vol, o_song_select, o_pause,
        output o_next, o_pre, o_vol_plus, o_vol_dec,
        output o_load_req
    );

    modport master (
        output i_bt_valid, i_bt_cmd, i_bt_arg,
        output i_key_valid, i_key_cmd, i_key_arg,
        output i_load_ack,
        input  o_bt_ready, o_key_ready,
        input  o_vol, o_song_select, o_pause,
        input  o_next, o_pre, o_vol_plus, o_vol_dec,
        input  o_load_req
    );
endinterface
`default_nettype wire

// File: rtl/player_cmd_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin grant. Grant is combinational;
//               the favour pointer only flips when both requesters were
//               competing in an enabled cycle, so a lone requester never
//               steals the other's next turn.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : grant allowed this cycle (a grant is always accepted)
//   req_i[1:0] : request vector, bit 0 = bt, bit 1 = key
//   gnt_o[1:0] : one-hot grant (or zero)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       en_i,
    input  wire logic [1:0] req_i,
    output logic      [1:0] gnt_o
);

    // 0 = bt wins the next collision, 1 = key wins it
    logic fav_q;
    logic fav_d;

    always_comb begin
        gnt_o = 2'b00;
        fav_d = fav_q;
        if (en_i) begin
            if (&req_i) begin
                gnt_o[fav_q] = 1'b1;
                fav_d        = ~fav_q;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fav_q <= 1'b0;
        end else begin
            fav_q <= fav_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/player_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : player_cmd_arbiter
// Description : Owns song index, volume attenuation and pause state.
//               Accepts one command at a time from two round-robin
//               arbitrated requesters, applies it, runs the decoder load
//               handshake on song changes and enforces a hold-off after
//               repeatable commands (NEXT/PRE/VOL_UP/VOL_DN).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : player_cmd_arbiter_if.slave (requesters, decoder
//                handshake, control state outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module player_cmd_arbiter
    import mp3_ctrl_pkg::*;
#(
    parameter int unsigned SONG_NUM = 4,
    parameter int unsigned VOL_STEP = C_VOL_STEP,
    parameter logic [7:0]  VOL_MAX  = C_VOL_MAX,
    parameter int unsigned HOLDOFF  = 5000000
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    player_cmd_arbiter_if.slave   bus
);

    localparam int unsigned C_CNT_W     = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(HOLDOFF - 1);
    localparam logic [2:0] C_SONG_LAST  = 3'(SONG_NUM - 1);
    localparam logic [3:0] C_SONG_NUM   = 4'(SONG_NUM);
    localparam logic [7:0] C_STEP       = 8'(VOL_STEP);

    state_t               state_q, state_d;
    logic [2:0]           cmd_q, cmd_d;
    logic [2:0]           arg_q, arg_d;
    logic [15:0]          vol_q, vol_d;
    logic [2:0]           song_q, song_d;
    logic                 pause_q, pause_d;
    logic                 next_q, next_d;
    logic                 pre_q, pre_d;
    logic                 vplus_q, vplus_d;
    logic                 vdec_q, vdec_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;

    logic [1:0]           w_gnt;
    logic                 w_sel_noop;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (state_q == ST_IDLE),
        .req_i ({bus.i_key_valid, bus.i_bt_valid}),
        .gnt_o (w_gnt)
    );

    // SEL outside the song range or onto the current song is swallowed
    assign w_sel_noop = ({1'b0, arg_q} >= C_SONG_NUM) || (arg_q == song_q);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        arg_d   = arg_q;
        vol_d   = vol_q;
        song_d  = song_q;
        pause_d = pause_q;
        next_d  = next_q;
        pre_d   = pre_q;
        vplus_d = vplus_q;
        vdec_d  = vdec_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (w_gnt[0]) begin
                    cmd_d   = bus.i_bt_cmd;
                    arg_d   = bus.i_bt_arg;
                    state_d = ST_EXEC;
                end else if (w_gnt[1]) begin
                    cmd_d   = bus.i_key_cmd;
                    arg_d   = bus.i_key_arg;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d = ST_IDLE;
                case (cmd_q)
                    C_CMD_PAUSE: begin
                        pause_d = ~pause_q;
                    end
                    C_CMD_NEXT: begin
                        song_d  = (song_q == C_SONG_LAST) ? 3'd0 : (song_q + 3'd1);
                        next_d  = 1'b1;
                        state_d = ST_LOAD;
                    end
                    C_CMD_PRE: begin
                        song_d  = (song_q == 3'd0) ? C_SONG_LAST : (song_q - 3'd1);
                        pre_d   = 1'b1;
                        state_d = ST_LOAD;
                    end
                    C_CMD_VOL_UP: begin
                        vol_d   = {vol_att_dec(vol_q[15:8], C_STEP),
                                   vol_att_dec(vol_q[7:0],  C_STEP)};
                        vplus_d = 1'b1;
                        state_d = ST_HOLD;
                    end
                    C_CMD_VOL_DN: begin
                        vol_d   = {vol_att_inc(vol_q[15:8], C_STEP, VOL_MAX),
                                   vol_att_inc(vol_q[7:0],  C_STEP, VOL_MAX)};
                        vdec_d  = 1'b1;
                        state_d = ST_HOLD;
                    end
                    C_CMD_SEL: begin
                        if (!w_sel_noop) begin
                            song_d  = arg_q;
                            state_d = ST_LOAD;
                        end
                    end
                    default: begin
                        // NOP and reserved code: consumed, nothing changes
                    end
                endcase
            end

            ST_LOAD: begin
                // Direct selection is not repeatable, so it skips hold-off
                if (bus.i_load_ack) begin
                    state_d = (cmd_q == C_CMD_SEL) ? ST_IDLE : ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (cnt_q == C_CNT_LAST) begin
                    cnt_d   = '0;
                    next_d  = 1'b0;
                    pre_d   = 1'b0;
                    vplus_d = 1'b0;
                    vdec_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + C_CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= C_CMD_NOP;
            arg_q   <= 3'd0;
            vol_q   <= 16'h0000;
            song_q  <= 3'd0;
            pause_q <= 1'b0;
            next_q  <= 1'b0;
            pre_q   <= 1'b0;
            vplus_q <= 1'b0;
            vdec_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            arg_q   <= arg_d;
            vol_q   <= vol_d;
            song_q  <= song_d;
            pause_q <= pause_d;
            next_q  <= next_d;
            pre_q   <= pre_d;
            vplus_q <= vplus_d;
            vdec_q  <= vdec_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_bt_ready    = (state_q == ST_IDLE) & w_gnt[0];
    assign bus.o_key_ready   = (state_q == ST_IDLE) & w_gnt[1];
    assign bus.o_vol         = vol_q;
    assign bus.o_song_select = song_q;
    assign bus.o_pause       = pause_q;
    assign bus.o_next        = next_q;
    assign bus.o_pre         = pre_q;
    assign bus.o_vol_plus    = vplus_q;
    assign bus.o_vol_dec     = vdec_q;
    assign bus.o_load_req    = (state_q == ST_LOAD);

endmodule
`default_nettype wire

// File: tb/tb_player_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_cmd_arbiter
// Description : Self-checking bench for player_cmd_arbiter. A transaction
//               level model predicts, for every cycle, the player state,
//               load request and ready strobes from command timing rules;
//               directed scenarios add hand-computed expectations, then a
//               randomized phase exercises both requesters and ack delays.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_cmd_arbiter;

    localparam int SONG_NUM = 4;
    localparam int HOLDOFF  = 8;
    localparam int VOL_STEP = 14;
    localparam int VOL_MAX  = 252;
    localparam longint INF  = 64'sh7FFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [2:0] cmd;
        logic [2:0] arg;
    } req_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    player_cmd_arbiter_if bus ();

    player_cmd_arbiter #(
        .SONG_NUM (SONG_NUM),
        .VOL_STEP (VOL_STEP),
        .VOL_MAX  (8'hFC),
        .HOLDOFF  (HOLDOFF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    req_t q_bt[$];
    req_t q_key[$];

    // Stimulus knobs
    bit ack_en   = 1'b1;
    bit ack_rand = 1'b0;
    int ack_dly  = 1;

    // Reference model state
    longint cyc = 0;
    longint m_idle_at = 0;
    longint m_apply_at = -1;
    bit     m_fav = 1'b0;
    int     vl = 0, vr = 0, e_song = 0;
    bit     e_pause, e_next, e_pre, e_vp, e_vd;
    bit     m_loading, m_hold_after;
    int     m_load_cnt = 0;
    int     p_vl, p_vr, p_song;
    bit     p_pause, p_next, p_pre, p_vp, p_vd, p_load;

    // Observations of the DUT
    int     cur_w = 0, last_w = 0, npulse = 0;
    longint bt_acc[$];
    longint key_acc[$];

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_idle_at = 0; m_apply_at = -1; m_fav = 1'b0;
        vl = 0; vr = 0; e_song = 0;
        e_pause = 0; e_next = 0; e_pre = 0; e_vp = 0; e_vd = 0;
        m_loading = 0; m_hold_after = 0; m_load_cnt = 0;
    endtask

    // Decide what an accepted command does, from the command rules
    task automatic plan(input logic [2:0] c, input logic [2:0] a);
        p_vl = vl; p_vr = vr; p_song = e_song; p_pause = e_pause;
        p_next = 0; p_pre = 0; p_vp = 0; p_vd = 0; p_load = 0;
        m_hold_after = 0;
        m_apply_at = cyc + 2;
        m_idle_at  = cyc + 2;
        case (c)
            3'd1: p_pause = !e_pause;
            3'd2: begin
                p_song = (e_song + 1) % SONG_NUM; p_next = 1;
                p_load = 1; m_hold_after = 1; m_idle_at = INF;
            end
            3'd3: begin
                p_song = (e_song + SONG_NUM - 1) % SONG_NUM; p_pre = 1;
                p_load = 1; m_hold_after = 1; m_idle_at = INF;
            end
            3'd4: begin
                p_vl = (vl < VOL_STEP) ? 0 : vl - VOL_STEP;
                p_vr = (vr < VOL_STEP) ? 0 : vr - VOL_STEP;
                p_vp = 1; m_idle_at = cyc + 2 + HOLDOFF;
            end
            3'd5: begin
                p_vl = (vl + VOL_STEP > VOL_MAX) ? VOL_MAX : vl + VOL_STEP;
                p_vr = (vr + VOL_STEP > VOL_MAX) ? VOL_MAX : vr + VOL_STEP;
                p_vd = 1; m_idle_at = cyc + 2 + HOLDOFF;
            end
            3'd6: begin
                if (int'(a) < SONG_NUM && int'(a) != e_song) begin
                    p_song = int'(a); p_load = 1; m_idle_at = INF;
                end
            end
            default: ;
        endcase
    endtask

    // Called at each rising edge: consumes the inputs of the cycle that
    // is ending and advances expectations to the next cycle.
    task automatic model_step();
        bit bv, kv, g;
        bv = bus.i_bt_valid;
        kv = bus.i_key_valid;
        if (m_loading) begin
            if (bus.i_load_ack) begin
                m_loading = 0;
                m_idle_at = m_hold_after ? cyc + 1 + HOLDOFF : cyc + 1;
            end else begin
                m_load_cnt++;
            end
        end else if (cyc >= m_idle_at && (bv || kv)) begin
            if (bv && kv) begin
                g = m_fav; m_fav = !m_fav;
            end else begin
                g = kv;
            end
            if (!g) begin
                plan(bus.i_bt_cmd, bus.i_bt_arg);
                void'(q_bt.pop_front());
            end else begin
                plan(bus.i_key_cmd, bus.i_key_arg);
                void'(q_key.pop_front());
            end
        end
        cyc++;
        if (cyc == m_apply_at) begin
            vl = p_vl; vr = p_vr; e_song = p_song; e_pause = p_pause;
            e_next = p_next; e_pre = p_pre; e_vp = p_vp; e_vd = p_vd;
            m_loading = p_load; m_load_cnt = 0;
        end
        if (cyc == m_idle_at) begin
            e_next = 0; e_pre = 0; e_vp = 0; e_vd = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (rst_n) model_step();
    end

    // Input driver: queue heads are presented until the model pops them
    task automatic drive();
        bus.i_bt_valid  = (q_bt.size() != 0);
        bus.i_bt_cmd    = (q_bt.size() != 0) ? q_bt[0].cmd : 3'd0;
        bus.i_bt_arg    = (q_bt.size() != 0) ? q_bt[0].arg : 3'd0;
        bus.i_key_valid = (q_key.size() != 0);
        bus.i_key_cmd   = (q_key.size() != 0) ? q_key[0].cmd : 3'd0;
        bus.i_key_arg   = (q_key.size() != 0) ? q_key[0].arg : 3'd0;
        if (ack_rand && !m_loading)
            bus.i_load_ack = ($urandom_range(0, 1) == 1);
        else
            bus.i_load_ack = ack_en && m_loading && (m_load_cnt >= ack_dly);
    endtask

    initial begin
        drive();
        forever begin
            @(posedge clk);
            #1;
            drive();
        end
    end

    // Per-cycle compare against the model
    initial forever begin
        logic [26:0] act, exp;
        bit idle, bv, kv, ebr, ekr;
        @(negedge clk);
        if (rst_n) begin
            bv   = bus.i_bt_valid;
            kv   = bus.i_key_valid;
            idle = (cyc >= m_idle_at);
            ebr  = idle && bv && (!kv || !m_fav);
            ekr  = idle && kv && (!bv || m_fav);
            exp  = {8'(vl), 8'(vr), 3'(e_song), e_pause, e_next, e_pre, e_vp,
                    e_vd, m_loading, ebr, ekr};
            act  = {bus.o_vol, bus.o_song_select, bus.o_pause, bus.o_next,
                    bus.o_pre, bus.o_vol_plus, bus.o_vol_dec, bus.o_load_req,
                    bus.o_bt_ready, bus.o_key_ready};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle_cmp cyc=%0d got=%h want=%h", cyc, act, exp);
            end
            if (bus.o_load_req) cur_w++;
            else if (cur_w != 0) begin
                last_w = cur_w; npulse++; cur_w = 0;
            end
            if (bv && bus.o_bt_ready)  bt_acc.push_back(cyc);
            if (kv && bus.o_key_ready) key_acc.push_back(cyc);
        end
    end

    task automatic push_bt(input logic [2:0] c, input logic [2:0] a);
        q_bt.push_back('{cmd: c, arg: a});
    endtask

    task automatic push_key(input logic [2:0] c, input logic [2:0] a);
        q_key.push_back('{cmd: c, arg: a});
    endtask

    task automatic wait_done(string name, int bound);
        int n = 0;
        while ((q_bt.size() != 0 || q_key.size() != 0 || cyc < m_idle_at) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) begin
            checks++; errors++;
            $display("FAIL %s: timeout after %0d cycles", name, n);
        end
    endtask

    task automatic assert_reset();
        @(negedge clk);
        rst_n = 1'b0;
        q_bt.delete();
        q_key.delete();
        model_reset();
        cur_w = 0;
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_exp[4] = '{1, 2, 3, 0};
        int np, n;

        model_reset();
        assert_reset();
        #1;
        chk("rst_async_vol", bus.o_vol, 0);
        release_reset();

        // Reset values
        chk("rst_vol",   bus.o_vol, 0);
        chk("rst_song",  bus.o_song_select, 0);
        chk("rst_flags", {bus.o_pause, bus.o_next, bus.o_pre, bus.o_vol_plus,
                          bus.o_vol_dec, bus.o_load_req}, 0);
        chk("rst_ready", {bus.o_bt_ready, bus.o_key_ready}, 0);

        // NEXT x4 with two-cycle load pulses
        ack_dly = 1;
        for (int i = 0; i < 4; i++) begin
            push_bt(3'd2, 3'd0);
            wait_done("next", 100);
            chk($sformatf("next%0d_song", i), bus.o_song_select, s_exp[i]);
            chk($sformatf("next%0d_pulse", i), last_w, 2);
        end
        chk("model_song_after_next", e_song, 0);

        // Volume saturation both ways
        push_bt(3'd5, 3'd0); wait_done("vdn1", 100);
        chk("vol_dn1", bus.o_vol, 16'h0E0E);
        push_bt(3'd4, 3'd0); wait_done("vup1", 100);
        chk("vol_up_to0", bus.o_vol, 16'h0000);
        push_bt(3'd4, 3'd0); wait_done("vup2", 100);
        chk("vol_up_floor", bus.o_vol, 16'h0000);
        for (int i = 0; i < 18; i++) begin
            push_key(3'd5, 3'd0); wait_done("vdn_loop", 100);
        end
        chk("vol_dn18", bus.o_vol, 16'hFCFC);
        push_key(3'd5, 3'd0); wait_done("vdn19", 100);
        chk("vol_dn_ceil", bus.o_vol, 16'hFCFC);
        chk("model_vol_ceil", vl, 252);

        // Collision: bt wins first, then key wins the next collision
        bt_acc.delete(); key_acc.delete();
        @(negedge clk);
        push_bt(3'd1, 3'd0);
        push_key(3'd3, 3'd0);
        wait_done("coll1", 100);
        chk("coll1_pause", bus.o_pause, 1);
        chk("coll1_song", bus.o_song_select, 3);
        chk("coll1_bt_first", (bt_acc.size() == 1 && key_acc.size() == 1 &&
                               bt_acc[0] < key_acc[0]) ? 1 : 0, 1);
        @(negedge clk);
        push_bt(3'd6, 3'd1);
        push_key(3'd6, 3'd2);
        wait_done("coll2", 100);
        chk("coll2_song", bus.o_song_select, 1);

        // SEL out of range and SEL onto current song: no load, 2 cycles each
        np = npulse;
        bt_acc.delete();
        @(negedge clk);
        push_bt(3'd6, 3'd7);
        push_bt(3'd6, 3'd1);
        wait_done("sel_noop", 100);
        chk("sel_noop_song", bus.o_song_select, 1);
        chk("sel_noop_pulses", npulse, np);
        chk("sel_noop_spacing", (bt_acc.size() == 2) ? bt_acc[1] - bt_acc[0] : -1, 2);

        // VOL_UP then key PAUSE: key waits out the hold-off
        bt_acc.delete(); key_acc.delete();
        @(negedge clk);
        push_bt(3'd4, 3'd0);
        @(negedge clk);
        push_key(3'd1, 3'd0);
        wait_done("hold_pause", 100);
        chk("hold_vol", bus.o_vol, 16'hEEEE);
        chk("hold_pause_toggle", bus.o_pause, 0);
        chk("hold_spacing", (bt_acc.size() == 1 && key_acc.size() == 1) ?
                            key_acc[0] - bt_acc[0] : -1, 10);

        // Reset while LOAD waits for an ack
        ack_en = 1'b0;
        push_bt(3'd2, 3'd0);
        n = 0;
        while (!bus.o_load_req && n < 20) begin @(negedge clk); n++; end
        chk("rst_load_seen", bus.o_load_req, 1);
        assert_reset();
        #1;
        chk("rstload_req",   bus.o_load_req, 0);
        chk("rstload_song",  bus.o_song_select, 0);
        chk("rstload_vol",   bus.o_vol, 0);
        chk("rstload_next",  bus.o_next, 0);
        ack_en = 1'b1;
        release_reset();
        push_bt(3'd2, 3'd0);
        wait_done("after_rst", 100);
        chk("after_rst_song", bus.o_song_select, 1);

        // Randomized traffic
        ack_rand = 1'b1;
        repeat (2000) begin
            @(negedge clk);
            if (!m_loading) ack_dly = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0 && q_bt.size() < 2)
                push_bt(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0 && q_key.size() < 2)
                push_key(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        wait_done("random_drain", 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/player_cmd_arbiter.md
# player_cmd_arbiter

Owns the shared player control state: song index, volume attenuation, pause. Two command requesters compete for it: the Bluetooth UART command decoder and the on-board key decoder. Arbitration is round-robin. The block applies one command at a time and enforces a hold-off after repeatable commands. It runs a load handshake with the MP3 decoder whenever the song index changes. It sits between both command front-ends and the decoder/volume/display datapath.

## Interface
- SONG_NUM, 4: number of songs; valid index range 0..SONG_NUM-1 (SONG_NUM ≤ 8).
- VOL_STEP, 14: attenuation change per volume command, per channel.
- VOL_MAX, 8'hFC: maximum per-channel attenuation.
- HOLDOFF, 5000000: hold-off length in clk cycles after NEXT/PRE/VOL_UP/VOL_DN.
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- i_bt_valid / i_key_valid  in  1  requester 0 / 1 command valid; held until accepted.
- i_bt_cmd / i_key_cmd  in  3  command code.
- i_bt_arg / i_key_arg  in  3  song index for SEL.
- o_bt_ready / o_key_ready  out  1  accept strobe.
- o_vol  out  16  attenuation; [15:8] left, [7:0] right. 0 = loudest.
- o_song_select  out  3  current song index.
- o_pause  out  1  1 = paused.
- o_next, o_pre, o_vol_plus, o_vol_dec  out  1  display flags.
- o_load_req  out  1  decoder reload request; level signal.
- i_load_ack  in  1  decoder acknowledge; level, sampled synchronously.

## Operation
- Command codes: 0 NOP, 1 PAUSE, 2 NEXT, 3 PRE, 4 VOL_UP, 5 VOL_DN, 6 SEL, 7 reserved. 7 is treated as NOP.
- Reset values: o_vol 0, o_song_select 0, o_pause 0, all display flags 0, o_load_req 0, both ready 0, state IDLE, RR pointer favours bt.
- States and transitions:
  - IDLE: grant one valid requester. If both are valid, grant the one not granted last; otherwise grant the only valid one. Assert its ready combinationally in IDLE only. Capture cmd/arg on valid&&ready. Go to EXEC. Toggle the RR pointer only when both were valid.
  - EXEC (1 cycle): apply the command.
    - PAUSE: toggle o_pause; go to IDLE.
    - NEXT: index+1, wrapping SONG_NUM-1→0.
    - PRE: index-1, wrapping 0→SONG_NUM-1.
    - NEXT and PRE: set o_next / o_pre; go to LOAD.
    - SEL: if arg ≥ SONG_NUM or arg == index, the command is consumed with no effect; go to IDLE. Otherwise index := arg; go to LOAD.
    - VOL_UP: each channel := (ch < VOL_STEP) ? 0 : ch-VOL_STEP. Set o_vol_plus. Go to HOLD.
    - VOL_DN: each channel := (ch > VOL_MAX-VOL_STEP) ? VOL_MAX : ch+VOL_STEP. Set o_vol_dec. Go to HOLD.
    - NOP/reserved: go to IDLE.
  - LOAD: o_load_req=1 until i_load_ack=1 is sampled. Then drop o_load_req. Go to HOLD if the command was NEXT/PRE, IDLE if it was SEL.
  - HOLD: count 0..HOLDOFF-1, then go to IDLE. Clear all display flags and the counter on exit.
- Both ready outputs are 0 in every state except IDLE. Requests are never dropped; they wait.
- Saturation is computed per channel. There is no carry between channel bytes.

## Timing
- Accept at cycle n (valid&&ready high). EXEC at n+1. New o_vol/o_song_select/o_pause/flags are visible at n+2.
- o_load_req rises at n+2. If ack is sampled high at cycle m, o_load_req is 0 at m+1.
- HOLD lasts exactly HOLDOFF cycles. The next ready can rise no earlier than n+2+HOLDOFF for VOL commands.
- PAUSE: the next accept is possible at n+2.
- Asserting rst_n low mid-LOAD or mid-HOLD returns every output to its reset value immediately. The count is discarded.

## Structure
- Shared package mp3_ctrl_pkg holds:
  - command code constants;
  - state encoding (IDLE, EXEC, LOAD, HOLD);
  - the default VOL_STEP/VOL_MAX constants.
- Sub-module rr_arb2 provides the 2-requester round-robin grant with its last-grant pointer.
- The FSM, per-channel saturating volume arithmetic, song index wrap and hold-off counter stay in the top.

## Test plan
Simulate with HOLDOFF=8.
- Reset, then bt NEXT ×4 with ack returned 2 cycles after each req → o_song_select 1,2,3,0. o_next is high through each HOLD. o_load_req pulses are 2 cycles long.
- o_vol=16'h0505, bt VOL_UP → 16'h0000. Then key VOL_DN ×19 → saturates at 16'hFCFC and stays there.
- Both valid in the same cycle (bt PAUSE, key PRE) → bt is granted first and o_pause=1. Key is granted next: index 0→3 and o_pre=1. The RR pointer alternates on the next collision.
- SEL arg=7, then SEL arg=index → no o_load_req, index unchanged, both consumed in 2 cycles each.
- VOL_UP followed immediately by key PAUSE → key ready stays low for the 8-cycle HOLD, then is accepted; o_pause toggles.
- rst_n low during LOAD (ack withheld) → o_load_req=0, o_song_select=0, state IDLE. After release, a fresh command is accepted normally.
